uart_word_sequencer: RTL and testbench
======================================

// Module: uart_word_sequencer
// PURPOSE
//  Sequencer between the UART RX byte FIFO and the core-side word consumer. On a start
//  command it drains the FIFO, packs 4 bytes (little-endian, first byte -> [7:0]) per
//  32-bit word, and hands each word over a valid/ready handshake. It stops after a
//  programmed word count, or flags a timeout when the FIFO stays empty too long.
// PARAMETERS
//  BYTES_PER_WORD  4     bytes packed per output word (word width = 8*BYTES_PER_WORD)
//  TIMEOUT_CYC     1024  consecutive FIFO-empty cycles in WAIT before abort (>=2)
//  CNT_W           16    width of word counter / i_word_count
// PORTS
//  Clk           in   1      system clock, rising edge
//  Rst           in   1      asynchronous, active-low reset
//  i_start       in   1      1-cycle pulse: arm transfer; ignored while o_busy=1
//  i_word_count  in   CNT_W  words to transfer, sampled on accepted i_start; 0 = no-op
//  i_fifo_empty  in   1      FIFO has no byte available
//  o_fifo_rd     out  1      FIFO read strobe, 1 cycle per byte
//  i_fifo_data   in   8      FIFO read data, valid the cycle AFTER o_fifo_rd
//  o_word        out  32     assembled word, held stable while o_word_valid=1
//  o_word_valid  out  1      word available
//  i_word_ready  in   1      consumer accepts when o_word_valid & i_word_ready
//  o_busy        out  1      transfer in progress (state != IDLE)
//  o_done        out  1      1-cycle pulse: last word accepted
//  o_timeout     out  1      sticky: abort on timeout; cleared by next accepted i_start
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE; all outputs 0; byte index, word and timeout counters 0.
//  States: IDLE -> WAIT -> CAPT -> (WAIT | PUSH) -> (WAIT | IDLE).
//   IDLE: on i_start & i_word_count!=0: load count, clear o_timeout, -> WAIT.
//         i_start with i_word_count=0: o_done pulses next cycle; state remains IDLE.
//   WAIT: if !i_fifo_empty: assert o_fifo_rd (combinational from state & !empty), -> CAPT.
//         Else increment the timeout counter. At TIMEOUT_CYC: set o_timeout, discard the
//         partial word, -> IDLE, no o_done.
//   CAPT: write i_fifo_data into byte lane byte_idx; reset the timeout counter.
//         If byte_idx = BYTES_PER_WORD-1: byte_idx <= 0, -> PUSH. Else byte_idx++, -> WAIT.
//   PUSH: o_word_valid=1. On handshake: decrement count. Count reaches 0: o_done=1 next
//         cycle, -> IDLE. Else -> WAIT.
//  Throughput: 2 cycles per byte, minimum 9 cycles per word when i_word_ready is held 1.
//  o_fifo_rd never asserts in CAPT/PUSH/IDLE, so the FIFO is never read on empty and
//  no byte is read beyond the programmed count.
//  Back-pressure: o_word_valid stays high and o_word stays frozen until ready; the timeout
//  counter does not run in PUSH.
//  i_start while busy: ignored, no effect on count or state.
//  Reset mid-transfer: immediate abort, partial word lost, FIFO untouched.
//  Count decrement wraps never (guarded by !=0); CNT_W-bit unsigned arithmetic.
// STRUCTURE
//  Shared uart package: state encodings (2-bit localparams ST_IDLE/WAIT/CAPT/PUSH),
//  BYTES_PER_WORD default, and byte-lane index width $clog2(BYTES_PER_WORD).
//  One natural sub-module: uart_timeout_ctr (load/clear, enable, terminal-count flag),
//  reusable by the TX side. FSM, packer register and word counter stay in this module.
// TESTING (bench wraps uart_fifo as the byte source)
//  1. Write 01..08 to FIFO, start count=2, ready=1 -> words 0x04030201, 0x08070605 in order,
//     o_done 1 cycle after second handshake, 8 o_fifo_rd pulses total.
//  2. Write 4 bytes, start count=1, ready=0 for 20 cycles -> valid high and word stable
//     the whole time, no extra o_fifo_rd; o_done after ready rises.
//  3. Write 2 bytes, start count=1, no more writes -> o_timeout=1 after TIMEOUT_CYC empty
//     cycles, busy=0, no o_word_valid, no o_done.
//  4. Start count=0 -> o_done pulse, busy never 1, no FIFO reads.
//  5. Second i_start pulse mid-transfer with count=5 -> ignored, original count honoured.
//  6. Drop Rst after 3 bytes captured -> all outputs 0 asynchronously; fresh start with
//     4 new bytes yields word built only from the new bytes.

Source files
------------

// File: rtl/uart_word_sequencer_pkg.sv
// Shared definitions for the UART RX word sequencer: FSM encoding, packing
// defaults and the byte-lane index width helper.
package uart_word_sequencer_pkg;

    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_TIMEOUT_CYC    = 1024;
    localparam int DEF_CNT_W          = 16;

    // A one-lane word still needs a 1-bit index so the packer logic stays uniform.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BYTE_IDX_W = idx_width(DEF_BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_PUSH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/uart_word_sequencer_if.sv
// Word hand-off channel between the sequencer (master) and the core consumer (slave).
interface uart_word_sequencer_if #(
    parameter int WORD_W = 32
) ();

    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/uart_timeout_ctr.sv
// Consecutive-cycle counter with clear, enable and a terminal-count flag that is
// high on the TERMINAL-th enabled cycle. Shared by the RX and TX sequencers.
module uart_timeout_ctr #(
    parameter int TERMINAL = 1024
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CTR_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [CTR_W-1:0] LAST_CNT = CTR_W'(TERMINAL - 1);

    logic [CTR_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last  = (r_count == LAST_CNT);
    assign o_terminal = w_at_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_at_last ? '0 : r_count + CTR_W'(1);
        end
    end

endmodule

// File: rtl/uart_word_sequencer.sv
// Drains the UART RX byte FIFO, packs bytes little-endian into words and hands
// them out over a valid/ready channel; stops on a word count or an empty-FIFO timeout.
module uart_word_sequencer
    import uart_word_sequencer_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  i_start,
    input  logic [CNT_W-1:0]      i_word_count,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    input  logic [7:0]            i_fifo_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    uart_word_sequencer_if.master word_if
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int IDX_W  = idx_width(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    seq_state_e         r_state;
    logic [IDX_W-1:0]   r_byte_idx;
    logic [WORD_W-1:0]  r_word;
    logic [CNT_W-1:0]   r_count;
    logic               r_valid;
    logic               r_done;
    logic               r_timeout;

    logic               w_to_clear;
    logic               w_to_enable;
    logic               w_to_expired;

    // Reads only from WAIT with data present: never on empty, never past the count.
    assign o_fifo_rd   = (r_state == ST_WAIT) && !i_fifo_empty;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_timeout   = r_timeout;
    assign word_if.word       = r_word;
    assign word_if.word_valid = r_valid;

    // The timer only measures the current empty stretch in WAIT.
    assign w_to_clear  = (r_state != ST_WAIT);
    assign w_to_enable = (r_state == ST_WAIT) && i_fifo_empty;

    uart_timeout_ctr #(
        .TERMINAL (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_clear    (w_to_clear),
        .i_enable   (w_to_enable),
        .o_terminal (w_to_expired)
    );

    // NOTE: every register here, the packed word included, is a flop bank rather
    // than a memory, so all of it takes the async reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= ST_IDLE;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_word_count != '0) begin
                            r_count    <= i_word_count;
                            r_timeout  <= 1'b0;
                            r_byte_idx <= '0;
                            r_state    <= ST_WAIT;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!i_fifo_empty) begin
                        r_state <= ST_CAPT;
                    end else if (w_to_expired && w_to_enable) begin
                        r_timeout  <= 1'b1;
                        r_byte_idx <= '0;
                        r_word     <= '0;
                        r_state    <= ST_IDLE;
                    end
                end

                ST_CAPT: begin
                    r_word[{r_byte_idx, 3'b000} +: 8] <= i_fifo_data;
                    if (r_byte_idx == LAST_IDX) begin
                        r_byte_idx <= '0;
                        r_valid    <= 1'b1;
                        r_state    <= ST_PUSH;
                    end else begin
                        r_byte_idx <= r_byte_idx + IDX_W'(1);
                        r_state    <= ST_WAIT;
                    end
                end

                ST_PUSH: begin
                    if (word_if.word_ready) begin
                        r_valid <= 1'b0;
                        if (r_count != '0) begin
                            r_count <= r_count - CNT_W'(1);
                        end
                        if (r_count <= CNT_W'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_sequencer.sv
// Directed bench for uart_word_sequencer: a behavioural byte FIFO feeds the DUT,
// expected words go to a scoreboard queue and are matched against observed handshakes.
module tb_uart_word_sequencer;
    import uart_word_sequencer_pkg::*;

    localparam int TO_CYC = 32;
    localparam int CNT_W  = 16;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              i_start = 1'b0;
    logic [CNT_W-1:0]  i_word_count = '0;
    logic              i_fifo_empty;
    logic              o_fifo_rd;
    logic [7:0]        i_fifo_data;
    logic              o_busy;
    logic              o_done;
    logic              o_timeout;

    uart_word_sequencer_if #(.WORD_W(32)) word_if ();

    uart_word_sequencer #(
        .BYTES_PER_WORD (4),
        .TIMEOUT_CYC    (TO_CYC),
        .CNT_W          (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .i_fifo_data  (i_fifo_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .word_if      (word_if)
    );

    always #5 Clk = ~Clk;

    // Byte FIFO: write visible next cycle, read data valid the cycle after o_fifo_rd.
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] fifo_q[$];
    int         fifo_level = 0;

    always @(posedge Clk) begin
        if (o_fifo_rd && fifo_q.size() > 0) i_fifo_data <= fifo_q.pop_front();
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_level <= fifo_q.size();
    end
    assign i_fifo_empty = (fifo_level == 0);

    // Observation side, sampled mid-cycle.
    int          cyc = 0, rd_cnt = 0, done_cnt = 0, busy_cnt = 0, valid_cnt = 0;
    int          unstable_cnt = 0, rd_empty_cnt = 0, done_cyc = 0;
    logic [31:0] obs_q[$];
    int          hs_cyc_q[$];
    logic [31:0] prev_word = '0;
    logic        prev_valid = 1'b0, prev_hs = 1'b0;

    always @(negedge Clk) begin
        cyc++;
        if (o_fifo_rd) rd_cnt++;
        if (o_fifo_rd && i_fifo_empty) rd_empty_cnt++;
        if (o_busy) busy_cnt++;
        if (word_if.word_valid) valid_cnt++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_valid && !prev_hs && word_if.word_valid && word_if.word !== prev_word)
            unstable_cnt++;
        if (word_if.word_valid && word_if.word_ready) begin
            obs_q.push_back(word_if.word);
            hs_cyc_q.push_back(cyc);
        end
        prev_word  = word_if.word;
        prev_valid = word_if.word_valid;
        prev_hs    = word_if.word_valid && word_if.word_ready;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    int          obs_rd = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fifo_write(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] n);
        i_word_count = n;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt), 32'(target));
    endtask

    task automatic compare_words(input string tag);
        while (exp_q.size() > 0) begin
            if (obs_rd < obs_q.size()) begin
                check(tag, obs_q[obs_rd], exp_q.pop_front());
                obs_rd++;
            end else begin
                check({tag, "_missing"}, 32'bx, exp_q.pop_front());
            end
        end
        check({tag, "_extra"}, 32'(obs_q.size() - obs_rd), 32'd0);
    endtask

    initial begin
        int rd0, d0, v0, b0, u0, n;
        word_if.word_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(word_if.word_valid), 32'd0);
        check("rst_word", word_if.word, 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_rd", 32'(o_fifo_rd), 32'd0);
        Rst = 1'b1;
        tick();

        // 1: two words at full rate
        rd0 = rd_cnt;
        for (int i = 1; i <= 8; i++) fifo_write(8'(i));
        exp_q.push_back(32'h0403_0201);
        exp_q.push_back(32'h0807_0605);
        pulse_start(16'd2);
        wait_done("t1_done", 1, 200);
        compare_words("t1_word");
        check("t1_rd_cnt", 32'(rd_cnt - rd0), 32'd8);
        check("t1_done_lat", 32'(done_cyc), 32'(hs_cyc_q[1] + 1));
        check("t1_word_period", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd9);
        tick();
        check("t1_idle", 32'(o_busy), 32'd0);

        // 2: back-pressure for 20 cycles
        word_if.word_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_write(8'hA0 + 8'(i));
        exp_q.push_back(32'hA3A2_A1A0);
        d0 = done_cnt;
        pulse_start(16'd1);
        n = 0;
        while (!word_if.word_valid && n < 50) begin
            tick();
            n++;
        end
        check("t2_valid_up", 32'(word_if.word_valid), 32'd1);
        rd0 = rd_cnt;
        v0  = valid_cnt;
        u0  = unstable_cnt;
        repeat (20) tick();
        check("t2_valid_held", 32'(valid_cnt - v0), 32'd20);
        check("t2_word_stable", 32'(unstable_cnt - u0), 32'd0);
        check("t2_no_extra_rd", 32'(rd_cnt - rd0), 32'd0);
        check("t2_no_early_done", 32'(done_cnt - d0), 32'd0);
        word_if.word_ready = 1'b1;
        wait_done("t2_done", d0 + 1, 20);
        compare_words("t2_word");

        // 3: FIFO runs dry mid-word
        fifo_write(8'h55);
        fifo_write(8'h66);
        rd0 = rd_cnt;
        d0  = done_cnt;
        v0  = valid_cnt;
        pulse_start(16'd1);
        n = 1;
        while (!o_timeout && n < TO_CYC + 50) begin
            tick();
            n++;
        end
        check("t3_timeout", 32'(o_timeout), 32'd1);
        check("t3_timeout_cycles", 32'(n), 32'(TO_CYC + 5));
        check("t3_busy", 32'(o_busy), 32'd0);
        check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t3_no_done", 32'(done_cnt - d0), 32'd0);
        check("t3_rd_cnt", 32'(rd_cnt - rd0), 32'd2);

        // 4: zero-count start
        rd0 = rd_cnt;
        b0  = busy_cnt;
        pulse_start(16'd0);
        check("t4_done_pulse", 32'(o_done), 32'd1);
        tick();
        check("t4_done_clear", 32'(o_done), 32'd0);
        check("t4_never_busy", 32'(busy_cnt - b0), 32'd0);
        check("t4_no_rd", 32'(rd_cnt - rd0), 32'd0);

        // 5: restart attempt while busy is ignored
        for (int i = 0; i < 20; i++) fifo_write(8'h10 + 8'(i));
        for (int w = 0; w < 5; w++)
            exp_q.push_back({8'h13 + 8'(4 * w), 8'h12 + 8'(4 * w), 8'h11 + 8'(4 * w), 8'h10 + 8'(4 * w)});
        rd0 = rd_cnt;
        d0  = done_cnt;
        pulse_start(16'd5);
        check("t5_timeout_cleared", 32'(o_timeout), 32'd0);
        repeat (6) tick();
        pulse_start(16'd2);
        wait_done("t5_done", d0 + 1, 300);
        compare_words("t5_word");
        check("t5_rd_cnt", 32'(rd_cnt - rd0), 32'd20);
        tick();
        check("t5_done_single", 32'(done_cnt - d0), 32'd1);
        check("t5_idle", 32'(o_busy), 32'd0);

        // 6: reset mid-word, then a clean transfer
        for (int i = 0; i < 3; i++) fifo_write(8'h11 * 8'(i + 1));
        rd0 = rd_cnt;
        pulse_start(16'd1);
        n = 0;
        while (rd_cnt - rd0 < 3 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("t6_busy_before_rst", 32'(o_busy), 32'd1);
        #2 Rst = 1'b0;
        #1;
        check("t6_rst_busy", 32'(o_busy), 32'd0);
        check("t6_rst_word", word_if.word, 32'd0);
        check("t6_rst_valid", 32'(word_if.word_valid), 32'd0);
        check("t6_rst_rd", 32'(o_fifo_rd), 32'd0);
        check("t6_rst_done", 32'(o_done), 32'd0);
        check("t6_rst_timeout", 32'(o_timeout), 32'd0);
        tick();
        tick();
        Rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) fifo_write(8'hC1 + 8'(i));
        exp_q.push_back(32'hC4C3_C2C1);
        d0 = done_cnt;
        pulse_start(16'd1);
        wait_done("t6_done", d0 + 1, 100);
        compare_words("t6_word");
        check("t6_fifo_drained", 32'(fifo_q.size()), 32'd0);

        check("never_rd_on_empty", 32'(rd_empty_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
